execute_stage: RTL and testbench



---
 rtl/execute_stage_if.sv | 29 ++
 rtl/execute_stage.sv | 116 +++++++++++
 tb/tb_execute_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Decode <-> execute bundle: register indices, immediate and control bits
// going in; ALU result, zero flag and both read operands coming back.
interface execute_stage_if;
    logic        we;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] rd1;
    logic [31:0] rd2;

    // Decode side drives control, consumes results.
    modport master (
        output we, alu_op, alu_src, rs1, rs2, rd, imm, funct3, funct7_5,
        input  alu_result, zero, rd1, rd2
    );

    // Execute stage consumes control, drives results.
    modport slave (
        input  we, alu_op, alu_src, rs1, rs2, rd, imm, funct3, funct7_5,
        output alu_result, zero, rd1, rd2
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: 32x32 register file with combinational reads,
// operand-B select, ALU control decode and a 32-bit ALU. The ALU result
// is written back to rd on the rising edge when we is set.

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    // Write port: async clear, writes to x0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // No bypass: a same-cycle write is only visible after the edge.
    assign rdata1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rdata2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

module execute_stage (
    input  logic             clk,
    input  logic             rst,
    execute_stage_if.slave   bus
);
    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_SLL  = 4'd2,
        FN_SLT  = 4'd3,
        FN_SLTU = 4'd4,
        FN_XOR  = 4'd5,
        FN_SRL  = 4'd6,
        FN_SRA  = 4'd7,
        FN_OR   = 4'd8,
        FN_AND  = 4'd9
    } alu_fn_e;

    alu_fn_e     fn_s;
    logic [31:0] op_a_s;
    logic [31:0] rd2_s;
    logic [31:0] op_b_s;
    logic [31:0] result_s;

    regfile rf (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.we),
        .wa     (bus.rd),
        .wd     (result_s),
        .ra1    (bus.rs1),
        .ra2    (bus.rs2),
        .rdata1 (op_a_s),
        .rdata2 (rd2_s)
    );

    assign op_b_s = bus.alu_src ? bus.imm : rd2_s;

    // ALU control: I-type never turns funct3=000 into SUB.
    always_comb begin
        fn_s = FN_ADD;
        case (bus.alu_op)
            2'b00: fn_s = FN_ADD;
            2'b01: fn_s = FN_SUB;
            default: begin
                case (bus.funct3)
                    3'b000: fn_s = ((bus.alu_op == 2'b10) && bus.funct7_5) ? FN_SUB : FN_ADD;
                    3'b001: fn_s = FN_SLL;
                    3'b010: fn_s = FN_SLT;
                    3'b011: fn_s = FN_SLTU;
                    3'b100: fn_s = FN_XOR;
                    3'b101: fn_s = bus.funct7_5 ? FN_SRA : FN_SRL;
                    3'b110: fn_s = FN_OR;
                    3'b111: fn_s = FN_AND;
                    default: fn_s = FN_ADD;
                endcase
            end
        endcase
    end

    // ALU datapath; shifts use only the low five bits of operand B.
    always_comb begin
        result_s = 32'd0;
        case (fn_s)
            FN_ADD:  result_s = op_a_s + op_b_s;
            FN_SUB:  result_s = op_a_s - op_b_s;
            FN_SLL:  result_s = op_a_s << op_b_s[4:0];
            FN_SLT:  result_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            FN_SLTU: result_s = {31'd0, (op_a_s < op_b_s)};
            FN_XOR:  result_s = op_a_s ^ op_b_s;
            FN_SRL:  result_s = op_a_s >> op_b_s[4:0];
            FN_SRA:  result_s = $unsigned($signed(op_a_s) >>> op_b_s[4:0]);
            FN_OR:   result_s = op_a_s | op_b_s;
            FN_AND:  result_s = op_a_s & op_b_s;
            default: result_s = 32'd0;
        endcase
    end

    assign bus.alu_result = result_s;
    assign bus.zero       = ~|result_s;
    assign bus.rd1        = op_a_s;
    assign bus.rd2        = rd2_s;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed literal cases followed by
// randomized instructions compared every cycle against a behavioural model.
module tb_execute_stage;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic check_en;
    logic [31:0] model_regs [0:31];

    execute_stage_if bus();

    execute_stage uut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from the instruction-set rules.
    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [2:0] f3,
                                              input logic f7, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        case (f3)
            3'd0: return ((op == 2'b10) && f7) ? (a - b) : (a + b);
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 && a[31]) ? ((a >> sh) | ~(32'hFFFFFFFF >> sh)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model_regs[idx];
    endfunction

    function automatic logic [31:0] model_result();
        logic [31:0] b;
        b = bus.alu_src ? bus.imm : model_read(bus.rs2);
        return model_alu(bus.alu_op, bus.funct3, bus.funct7_5, model_read(bus.rs1), b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model register file: async clear, writeback at the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
        end else if (bus.we === 1'b1 && bus.rd != 5'd0) begin
            model_regs[bus.rd] <= model_result();
        end
    end

    // Per-cycle comparison of all outputs and one register against the model.
    always @(negedge clk) begin
        if (check_en) begin
            int k;
            logic [31:0] e;
            e = model_result();
            check("alu_result", bus.alu_result, e);
            check("zero", {31'd0, bus.zero}, {31'd0, (e == 32'd0)});
            check("rd1", bus.rd1, model_read(bus.rs1));
            check("rd2", bus.rd2, model_read(bus.rs2));
            k = $urandom_range(0, 31);
            check("regfile", uut.rf.regs[k], model_regs[k]);
        end
    end

    task automatic apply(input logic we, input logic [1:0] op, input logic src,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic [31:0] im, input logic [2:0] f3, input logic f7);
        bus.we = we; bus.alu_op = op; bus.alu_src = src;
        bus.rs1 = r1; bus.rs2 = r2; bus.rd = d;
        bus.imm = im; bus.funct3 = f3; bus.funct7_5 = f7;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a register through the datapath: x0 + imm -> rd.
    task automatic set_reg(input logic [4:0] n, input logic [31:0] v);
        apply(1'b1, 2'b00, 1'b1, 5'd0, 5'd0, n, v, 3'd0, 1'b0);
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        check_en = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        rst = 1'b1;
        apply(1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b0);
        #12;
        check("reset_x5", uut.rf.regs[5], 32'd0);
        check("reset_zero", {31'd0, bus.zero}, 32'd1);
        rst = 1'b0;
        check_en = 1'b1;

        // R-type ADD with writeback
        step();
        set_reg(5'd1, 32'd10);
        set_reg(5'd2, 32'd15);
        apply(1'b1, 2'b10, 1'b0, 5'd1, 5'd2, 5'd5, 32'd0, 3'd0, 1'b0);
        #1;
        check("radd", bus.alu_result, 32'd25);
        check("radd_zero", {31'd0, bus.zero}, 32'd0);
        check("radd_nobypass", bus.rd1, 32'd10);
        step();
        check("radd_wb", uut.rf.regs[5], 32'd25);
        check("radd_x1", uut.rf.regs[1], 32'd10);
        check("radd_x2", uut.rf.regs[2], 32'd15);

        // SUB and zero flag
        set_reg(5'd1, 32'd7);
        set_reg(5'd2, 32'd7);
        apply(1'b0, 2'b01, 1'b0, 5'd1, 5'd2, 5'd6, 32'd0, 3'd0, 1'b0);
        #1;
        check("sub_eq", bus.alu_result, 32'd0);
        check("sub_zero", {31'd0, bus.zero}, 32'd1);
        step();
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd9);
        apply(1'b0, 2'b10, 1'b0, 5'd1, 5'd2, 5'd6, 32'd0, 3'd0, 1'b1);
        #1;
        check("rsub_neg", bus.alu_result, 32'hFFFFFFFC);

        // I-type ignores funct7_5 on ADD; shifts
        step();
        set_reg(5'd1, 32'd10);
        apply(1'b0, 2'b11, 1'b1, 5'd1, 5'd0, 5'd6, 32'hFFFFFFFD, 3'd0, 1'b1);
        #1;
        check("addi_f7", bus.alu_result, 32'd7);
        step();
        set_reg(5'd1, 32'h80000000);
        apply(1'b0, 2'b11, 1'b1, 5'd1, 5'd0, 5'd6, 32'd4, 3'd5, 1'b0);
        #1;
        check("srli", bus.alu_result, 32'h08000000);
        bus.funct7_5 = 1'b1;
        #1;
        check("srai", bus.alu_result, 32'hF8000000);

        // Compare and logic ops
        step();
        set_reg(5'd1, 32'hFFFFFFFF);
        set_reg(5'd2, 32'd1);
        apply(1'b0, 2'b10, 1'b0, 5'd1, 5'd2, 5'd6, 32'd0, 3'd2, 1'b0);
        #1; check("slt", bus.alu_result, 32'd1);
        bus.funct3 = 3'd3; #1; check("sltu", bus.alu_result, 32'd0);
        bus.funct3 = 3'd4; #1; check("xor", bus.alu_result, 32'hFFFFFFFE);
        bus.funct3 = 3'd6; #1; check("or", bus.alu_result, 32'hFFFFFFFF);
        bus.funct3 = 3'd7; #1; check("and", bus.alu_result, 32'd1);

        // x0 protection and we=0
        step();
        set_reg(5'd1, 32'd10);
        set_reg(5'd2, 32'd15);
        apply(1'b1, 2'b10, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 3'd0, 1'b0);
        step();
        check("x0_store", uut.rf.regs[0], 32'd0);
        apply(1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 3'd0, 1'b0);
        #1;
        check("x0_read", bus.rd1, 32'd0);
        bus.rs1 = 5'd1;
        step();
        check("we0_keep", uut.rf.regs[5], 32'd25);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_clear", uut.rf.regs[5], 32'd0);
        apply(1'b1, 2'b00, 1'b1, 5'd0, 5'd0, 5'd5, 32'd123, 3'd0, 1'b0);
        step();
        step();
        check("arst_block", uut.rf.regs[5], 32'd0);
        #2;
        rst = 1'b0;
        step();
        check("arst_release", uut.rf.regs[5], 32'd123);

        // Randomized instructions with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            step();
            bus.we       = ($urandom_range(0, 3) != 0);
            bus.alu_op   = 2'($urandom_range(0, 3));
            bus.alu_src  = 1'($urandom_range(0, 1));
            bus.rs1      = 5'($urandom_range(0, 31));
            bus.rs2      = 5'($urandom_range(0, 31));
            bus.rd       = 5'($urandom_range(0, 31));
            bus.imm      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom)));
            bus.funct3   = 3'($urandom_range(0, 7));
            bus.funct7_5 = 1'($urandom_range(0, 1));
            if (i % 97 == 50) begin
                #2;
                rst = 1'b1;
                #4;
                rst = 1'b0;
            end
        end
        step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
